// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 keyboard receiver and its event FIFO.
package ps2_pkg;

    localparam logic [7:0] KBD_E0 = 8'hE0;
    localparam logic [7:0] KBD_F0 = 8'hF0;
    localparam logic [7:0] KBD_E1 = 8'hE1;

    localparam int EV_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } kbd_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } kbd_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through sync FIFO; a push into a full FIFO is dropped and flagged unless a pop frees the slot.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = EV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         overflow,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to reuse.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: glitch-filtered clock, 11-bit frame capture with timeout,
// E0/F0 prefix decoding into make/break events queued in a small FIFO.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_release,
    output logic [7:0] scancode,
    output logic       frame_err,
    output logic       overflow
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HALF = FILTER_LEN / 2;

    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic                  clk_p0, clk_p1;
    logic                  data_p0, data_p1;
    logic [FILTER_LEN-1:0] clk_hist;
    logic                  fall_edge;
    logic [3:0]            cnt;
    logic [9:0]            sr;
    logic [TO_W-1:0]       to_cnt;
    logic                  frame_done;
    logic                  frame_ok;
    logic                  timeout_hit;
    logic                  byte_vld;
    logic                  abort;
    logic [7:0]            rx_byte;
    kbd_state_t            st, st_nxt;
    logic                  ev_push;
    kbd_event_t            ev_new;
    kbd_event_t            ev_head;
    logic                  fifo_empty;

    // A fall is accepted only after HALF steady highs followed by HALF steady lows.
    assign fall_edge   = (clk_hist[FILTER_LEN-1 -: HALF] == '1) && (clk_hist[HALF-1:0] == '0);
    assign frame_done  = fall_edge && (cnt == 4'd10);
    assign rx_byte     = sr[8:1];
    assign frame_ok    = !sr[0] && data_p1 && odd_parity_ok(rx_byte, sr[9]);
    assign byte_vld    = frame_done && frame_ok;
    assign timeout_hit = !fall_edge && (cnt != 4'd0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign abort       = (frame_done && !frame_ok) || timeout_hit;

    // Stage: input synchronisers, clock filter, bit capture and timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_p0    <= 1'b0;
            clk_p1    <= 1'b0;
            data_p0   <= 1'b0;
            data_p1   <= 1'b0;
            clk_hist  <= '0;
            cnt       <= 4'd0;
            sr        <= '0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
            scancode  <= 8'h00;
        end else begin
            clk_p0    <= ps2clk;
            clk_p1    <= clk_p0;
            data_p0   <= ps2data;
            data_p1   <= data_p0;
            clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_p1};
            frame_err <= abort;
            if (fall_edge) begin
                to_cnt <= '0;
                if (cnt == 4'd10) begin
                    cnt <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                    sr  <= {data_p1, sr[9:1]};
                end
            end else if (cnt != 4'd0) begin
                if (timeout_hit) begin
                    cnt    <= 4'd0;
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
            if (ev_push && ev_new.rel) scancode <= ev_new.code;
        end
    end

    // Stage: prefix FSM
    always_ff @(posedge clk) begin
        if (reset) st <= ST_IDLE;
        else       st <= st_nxt;
    end

    always_comb begin
        st_nxt  = st;
        ev_push = 1'b0;
        ev_new  = '0;
        if (abort) begin
            st_nxt = ST_IDLE;
        end else if (byte_vld) begin
            if (rx_byte == KBD_E0) begin
                st_nxt = ST_E0;
            end else if (rx_byte == KBD_F0 && st == ST_IDLE) begin
                st_nxt = ST_F0;
            end else if (rx_byte == KBD_F0 && st == ST_E0) begin
                st_nxt = ST_E0F0;
            end else begin
                ev_push     = 1'b1;
                ev_new.ext  = (st == ST_E0) || (st == ST_E0F0);
                ev_new.rel  = (st == ST_F0) || (st == ST_E0F0);
                ev_new.code = rx_byte;
                st_nxt      = ST_IDLE;
            end
        end
    end

    // Stage: event queue
    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (ev_push),
        .din      (ev_new),
        .overflow (overflow),
        .pop      (ev_ready),
        .empty    (fifo_empty),
        .dout     (ev_head)
    );

    assign ev_valid   = !fifo_empty;
    assign ev_code    = ev_head.code;
    assign ev_ext     = ev_head.ext;
    assign ev_release = ev_head.rel;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: make/break/extended decoding, frame errors, timeout and FIFO overflow.
module tb_ps2_kbd_rx;

    localparam int TO       = 2000;
    localparam int BIT_HALF = 100;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2clk   = 1'b1;
    logic       ps2data  = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_release;
    logic [7:0] scancode;
    logic       frame_err;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int ovf_cnt  = 0;
    int e0;
    int o0;
    int hit;

    ps2_kbd_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2clk     (ps2clk),
        .ps2data    (ps2data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_release (ev_release),
        .scancode   (scancode),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_cnt++;
        if (overflow)  ovf_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit pop_at_fall);
        @(negedge clk) ps2data = b;
        repeat (BIT_HALF) @(negedge clk);
        ps2clk = 1'b0;
        if (pop_at_fall) begin
            // The event is pushed on the 7th edge after the fall; pop on that same edge.
            repeat (6) @(negedge clk);
            ev_ready = 1'b1;
            @(negedge clk);
            ev_ready = 1'b0;
            repeat (BIT_HALF - 7) @(negedge clk);
        end else begin
            repeat (BIT_HALF) @(negedge clk);
        end
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic start_b,
                              input logic stop_b, input bit pop_at_push);
        send_bit(start_b, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(~(^d) ^ bad_par, 1'b0);
        send_bit(stop_b, pop_at_push);
        ps2data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code, input logic ext, input logic rel);
        chk({tag, "_valid"}, ev_valid, 1'b1);
        chk({tag, "_code"}, ev_code, code);
        chk({tag, "_ext"}, ev_ext, ext);
        chk({tag, "_rel"}, ev_release, rel);
        @(negedge clk) ev_ready = 1'b1;
        @(negedge clk) ev_ready = 1'b0;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_code", ev_code, 8'h00);
        chk("rst_scancode", scancode, 8'h00);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        repeat (10) @(negedge clk);

        // Plain make code
        e0 = err_cnt;
        good(8'h1C);
        chk("t1_scancode", scancode, 8'h00);
        expect_event("t1", 8'h1C, 1'b0, 1'b0);
        chk("t1_empty", ev_valid, 1'b0);
        chk("t1_noerr", err_cnt - e0, 0);

        // Break code
        good(8'hF0);
        chk("t2_f0_noevent", ev_valid, 1'b0);
        good(8'h1C);
        chk("t2_scancode", scancode, 8'h1C);
        expect_event("t2", 8'h1C, 1'b0, 1'b1);

        // Extended break then extended make
        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        chk("t3_scancode", scancode, 8'h75);
        expect_event("t3a", 8'h75, 1'b1, 1'b1);
        chk("t3_one_event", ev_valid, 1'b0);
        good(8'hE0);
        good(8'h75);
        expect_event("t3b", 8'h75, 1'b1, 1'b0);
        chk("t3_scancode_kept", scancode, 8'h75);

        // Bad parity, then recovery
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("t4_par_err", err_cnt - e0, 1);
        chk("t4_par_noevent", ev_valid, 1'b0);
        good(8'h1C);
        expect_event("t4_par_next", 8'h1C, 1'b0, 1'b0);
        // Bad start after an F0 prefix: the prefix must be forgotten
        e0 = err_cnt;
        good(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_start_err", err_cnt - e0, 1);
        chk("t4_start_noevent", ev_valid, 1'b0);
        good(8'h1C);
        expect_event("t4_start_next", 8'h1C, 1'b0, 1'b0);
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_stop_err", err_cnt - e0, 1);
        chk("t4_stop_noevent", ev_valid, 1'b0);

        // Timeout after 5 bits
        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk) ps2data = 1'b1;
        repeat (BIT_HALF) @(negedge clk);
        ps2clk = 1'b0;
        hit = 0;
        for (int i = 1; i <= 2100; i++) begin
            @(negedge clk);
            if (i == BIT_HALF) ps2clk = 1'b1;
            if (frame_err && hit == 0) hit = i;
        end
        // 2 sync + 4 filter edges, fall accepted on edge 7, then 2000 idle cycles.
        chk("t5_timeout_cycle", hit, 7 + TO);
        chk("t5_single_pulse", err_cnt - e0, 1);
        chk("t5_noevent", ev_valid, 1'b0);
        good(8'h2A);
        expect_event("t5_next", 8'h2A, 1'b0, 1'b0);

        // Reset in the middle of a frame discards it
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1 == 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("rst_mid_scancode", scancode, 8'h00);
        repeat (10) @(negedge clk);
        good(8'h1C);
        expect_event("rst_mid_next", 8'h1C, 1'b0, 1'b0);

        // FIFO fill and overflow
        o0 = ovf_cnt;
        for (int b = 8'h10; b <= 8'h18; b++) begin
            good(8'(b));
            if (b == 8'h10) chk("t6_head_first", ev_code, 8'h10);
            if (b == 8'h17) chk("t6_no_ovf_at_full", ovf_cnt - o0, 0);
        end
        chk("t6_ovf_once", ovf_cnt - o0, 1);
        chk("t6_head_stable", ev_code, 8'h10);
        chk("t6_valid", ev_valid, 1'b1);
        send_frame(8'h19, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_push_pop_no_ovf", ovf_cnt - o0, 1);
        for (int b = 8'h11; b <= 8'h17; b++) expect_event("t6_pop", 8'(b), 1'b0, 1'b0);
        expect_event("t6_pop_last", 8'h19, 1'b0, 1'b0);
        chk("t6_drained", ev_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
